keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces the result and emits one 4-bit key code per accepted press.
- It is the input-side counterpart of the multiplexed seven-segment display path: a time-multiplexed matrix that is read rather than driven.
- Sits at the board edge and feeds the stopwatch/control logic with key events.

Parameters:
- SCAN_DIV, 50000, clk cycles each column is held active (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- row  input  4  keypad row lines, active-low (pulled up; 0 = key closed in the active column); asynchronous to clk.
- col  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key_code  output  4  last accepted key, code = row_index*4 + col_index.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_down  output  1  high while the accepted key is held (until debounced release).

Behaviour:
- Reset (reset==0 at a clk edge):
  - col=4'b1110 (column 0); dwell counter=0; column index=0.
  - Row synchronizer flops=4'b1111; snapshot and previous snapshot=0; match counter=0.
  - FSM=IDLE; key_code=0; key_valid=0; key_down=0.
  - Reset asserted mid-scan or mid-press aborts everything; no key_valid is produced for a press in progress.
- Row input: two-flop synchronizer on row; only synchronized values are used.
- Scan timing:
  - Dwell counter counts 0..SCAN_DIV-1, then wraps and advances the column index 0->1->2->3->0.
  - col = ~(1<<index), registered.
  - Full scan period = 4*SCAN_DIV cycles.
  - Sampling happens on the dwell cycle SCAN_DIV-1; the preceding cycles allow settling plus synchronizer latency.
  - At each sample, inverted synchronized rows are stored into snapshot bits [r*4+c] for the current column c.
- scan_end: the sample cycle of column 3. At scan_end the complete 16-bit snapshot is classified as:
  - NONE: all zero.
  - SINGLE(k): exactly one bit set, k = its index.
  - MULTI: two or more bits set. MULTI is treated as NONE for acceptance (ghost rejection), but breaks any candidate match.
- FSM, evaluated only at scan_end (no state change on other cycles):
  - IDLE: on SINGLE(k) -> CAND with cand=k, match=1; otherwise stay. If DEBOUNCE_SCANS==1, go directly to accept.
  - CAND:
    - SINGLE(cand) -> match+1.
    - When match reaches DEBOUNCE_SCANS -> accept.
    - SINGLE(j), j!=cand -> cand=j, match=1.
    - NONE or MULTI -> IDLE, match=0.
  - Accept: key_code<=cand; key_valid=1 for exactly the cycle after scan_end; key_down<=1 on that same cycle; FSM -> PRESSED.
  - PRESSED:
    - NONE increments rel counter.
    - Any non-NONE resets rel to 0; this includes other keys and MULTI, which are otherwise ignored.
    - When rel reaches DEBOUNCE_SCANS -> key_down<=0 on the cycle after scan_end; FSM -> IDLE.
- Holding a key never repeats key_valid.
- key_code holds its value through release and changes only on the next accept.
- Latency: a press held stable from scan start is accepted DEBOUNCE_SCANS full scans later; key_valid rises 1 cycle after that scan_end.
- Counter widths: dwell sized by $clog2(SCAN_DIV); match/rel by $clog2(DEBOUNCE_SCANS+1). Counters saturate and never wrap in the FSM.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3 -> 16-cycle scan):
- Reset, row=4'b1111 -> col=1110 during and after reset; then 1110,1101,1011,0111 each for 4 cycles, repeating; key_valid=0, key_down=0, key_code=0.
- Model drives row[2]=0 whenever col[1]=0, steady from scan 0 -> exactly one key_valid pulse 1 cycle after the 3rd scan_end; key_code=9; key_down=1; no further pulses while held for 10 scans.
- Bounce: key 9 present 2 scans, absent 1, present 3 -> no pulse after the first 2 scans; a single pulse after the 3rd consecutive good scan.
- Two keys (code 0: row0/col0; code 5: row1/col1) held 6 scans -> no key_valid, key_down=0; then release key 5 -> key 0 accepted 3 scans later, key_code=0.
- Release: after key 9 accepted, drop to no keys -> key_down falls 1 cycle after the 3rd empty scan_end; a 1-scan re-press in between restarts the count; key_code stays 9.
- Reset mid-press: key held 2 scans, reset low for 1 cycle -> all outputs reset values, col=1110; the press is accepted only after 3 full scans post-reset.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with scan-level debounce and one-shot key events
module keypad_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_SCANS - 1);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;

    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [3:0]    row_s1, row_s2;
    logic [15:0]   snapshot, snap_full;
    state_t        state, state_n;
    logic [3:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    key_code_n;
    logic          key_valid_n, key_down_n;
    logic [4:0]    ones;
    logic [3:0]    hit;
    logic          accept;

    wire sample   = (dwell == DWELL_LAST);
    wire scan_end = sample && (col_idx == 2'd3);
    wire single   = (ones == 5'd1);

    // Snapshot with the active column's bits overlaid, so scan_end sees all 16 keys at once.
    always_comb begin
        snap_full = snapshot;
        for (int r = 0; r < 4; r++)
            snap_full[{2'(r), col_idx}] = ~row_s2[r];
    end

    always_comb begin
        ones = '0;
        hit  = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                ones = ones + 5'd1;
                hit  = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dwell     <= '0;
            col_idx   <= 2'd0;
            col       <= 4'b1110;
            row_s1    <= 4'b1111;
            row_s2    <= 4'b1111;
            snapshot  <= '0;
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (sample) begin
                dwell    <= '0;
                col_idx  <= col_idx + 2'd1;
                col      <= ~(4'b0001 << (col_idx + 2'd1));
                snapshot <= snap_full;
            end else begin
                dwell <= dwell + DW'(1);
            end
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_down  <= key_down_n;
        end
    end

    // cnt is the match count in CAND and the release count in PRESSED.
    always_comb begin
        state_n     = state;
        cand_n      = cand;
        cnt_n       = cnt;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_down_n  = key_down;
        accept      = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand_n  = hit;
                        cnt_n   = CW'(1);
                        state_n = CAND;
                        if (CNT_LAST == '0) accept = 1'b1;
                    end
                end
                CAND: begin
                    if (single) begin
                        if (hit == cand) begin
                            if (cnt == CNT_LAST) accept = 1'b1;
                            else cnt_n = cnt + CW'(1);
                        end else begin
                            cand_n = hit;
                            cnt_n  = CW'(1);
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (ones == 5'd0) begin
                        if (cnt == CNT_LAST) begin
                            key_down_n = 1'b0;
                            state_n    = IDLE;
                            cnt_n      = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
            if (accept) begin
                key_code_n  = cand_n;
                key_valid_n = 1'b1;
                key_down_n  = 1'b1;
                state_n     = PRESSED;
                cnt_n       = '0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - table-driven and randomized bench for keypad_scanner with a scan-level keypad model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam logic [15:0] N  = 16'h0000;
    localparam logic [15:0] K0 = 16'h0001;
    localparam logic [15:0] K3 = 16'h0008;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K7 = 16'h0080;
    localparam logic [15:0] K9 = 16'h0200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row, col, key_code;
    logic       key_valid, key_down;
    logic [15:0] keys = '0;

    int vectors = 0;
    int miscompares = 0;

    int m_state, m_cand, m_cnt, m_code;
    bit m_down, m_valid;

    typedef struct {
        logic [15:0] keys;
        logic        v;
        logic        d;
        logic [3:0]  code;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    // Physical keypad: a closed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            if (col[c] == 1'b0)
                for (int r = 0; r < 4; r++)
                    if (keys[r*4+c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_cand = 0; m_cnt = 0; m_code = 0; m_down = 0; m_valid = 0;
    endtask

    // One full scan with a stable key set: classify, then apply the debounce rules.
    task automatic model_scan(input logic [15:0] m);
        int n, k;
        bit acc;
        n = $countones(m);
        k = 0;
        for (int i = 0; i < 16; i++) if (m[i]) k = i;
        m_valid = 0;
        acc = 0;
        if (m_state == 0) begin
            if (n == 1) begin m_state = 1; m_cand = k; m_cnt = 1; acc = (m_cnt >= DS); end
        end else if (m_state == 1) begin
            if (n == 1) begin
                if (k == m_cand) m_cnt++;
                else begin m_cand = k; m_cnt = 1; end
                acc = (m_cnt >= DS);
            end else begin
                m_state = 0; m_cnt = 0;
            end
        end else begin
            if (n == 0) begin
                m_cnt++;
                if (m_cnt >= DS) begin m_down = 0; m_state = 0; m_cnt = 0; end
            end else m_cnt = 0;
        end
        if (acc) begin
            m_code = m_cand; m_valid = 1; m_down = 1; m_state = 2; m_cnt = 0;
        end
    endtask

    task automatic run_scan(input logic [15:0] m, output logic v, output logic d,
                            output logic [3:0] code, output int bad);
        keys = m;
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (col !== ~(4'b0001 << ((i / 4) % 4))) bad++;
            if (i < 16 && key_valid !== 1'b0) bad++;
        end
        v = key_valid;
        d = key_down;
        code = key_code;
        model_scan(m);
    endtask

    task automatic scan_expect(input logic [15:0] m, input logic ev, input logic ed, input logic [3:0] ec);
        logic v, d;
        logic [3:0] code;
        int bad;
        run_scan(m, v, d, code, bad);
        check("key_valid", 32'(v), 32'(ev));
        check("key_down", 32'(d), 32'(ed));
        check("key_code", 32'(code), 32'(ec));
        check("col_and_pulse_timing", bad, 0);
    endtask

    task automatic check_reset_state();
        check("reset_col", 32'(col), 32'h0e);
        check("reset_key_valid", 32'(key_valid), 0);
        check("reset_key_down", 32'(key_down), 0);
        check("reset_key_code", 32'(key_code), 0);
    endtask

    task automatic add(input logic [15:0] k, input logic v, input logic d, input logic [3:0] c, input int n);
        vec_t e;
        e.keys = k; e.v = v; e.d = d; e.code = c;
        for (int i = 0; i < n; i++) tbl.push_back(e);
    endtask

    initial begin
        logic [15:0] cur;
        int r;

        // press key 9, hold
        add(N, 0, 0, 4'd0, 1);
        add(K9, 0, 0, 4'd0, 2);
        add(K9, 1, 1, 4'd9, 1);
        add(K9, 0, 1, 4'd9, 10);
        // release with a one-scan re-press in the middle
        add(N, 0, 1, 4'd9, 2);
        add(K9, 0, 1, 4'd9, 1);
        add(N, 0, 1, 4'd9, 2);
        add(N, 0, 0, 4'd9, 1);
        // bounce
        add(K9, 0, 0, 4'd9, 2);
        add(N, 0, 0, 4'd9, 1);
        add(K9, 0, 0, 4'd9, 2);
        add(K9, 1, 1, 4'd9, 1);
        add(N, 0, 1, 4'd9, 2);
        add(N, 0, 0, 4'd9, 1);
        // two keys are ghost-rejected, then the survivor is accepted
        add(K0 | K5, 0, 0, 4'd9, 6);
        add(K0, 0, 0, 4'd9, 2);
        add(K0, 1, 1, 4'd0, 1);
        add(N, 0, 1, 4'd0, 2);
        add(N, 0, 0, 4'd0, 1);
        // candidate switch, other key and multi while held
        add(K3, 0, 0, 4'd0, 2);
        add(K7, 0, 0, 4'd0, 2);
        add(K7, 1, 1, 4'd7, 1);
        add(K3, 0, 1, 4'd7, 1);
        add(N, 0, 1, 4'd7, 2);
        add(K7 | K0, 0, 1, 4'd7, 1);
        add(N, 0, 1, 4'd7, 2);
        add(N, 0, 0, 4'd7, 1);

        reset = 1'b0;
        keys = N;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b1;

        foreach (tbl[i]) scan_expect(tbl[i].keys, tbl[i].v, tbl[i].d, tbl[i].code);

        cur = N;
        for (int s = 0; s < 80; s++) begin
            logic v, d;
            logic [3:0] code;
            int bad;
            r = $urandom_range(0, 9);
            if (r >= 5 && r < 7) cur = N;
            else if (r >= 7 && r < 9) cur = 16'(1) << $urandom_range(0, 15);
            else if (r == 9) cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
            run_scan(cur, v, d, code, bad);
            check("rand_key_valid", 32'(v), 32'(m_valid));
            check("rand_key_down", 32'(d), 32'(m_down));
            check("rand_key_code", 32'(code), 32'(m_code));
            check("rand_timing", bad, 0);
        end

        // reset in the middle of a press in progress
        for (int s = 0; s < 3; s++) begin
            logic v, d;
            logic [3:0] code;
            int bad;
            run_scan(N, v, d, code, bad);
        end
        scan_expect(K9, 0, 0, 4'(m_code));
        scan_expect(K9, 0, 0, 4'(m_code));
        repeat (7) begin @(posedge clk); @(negedge clk); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state();
        reset = 1'b1;
        model_reset();
        scan_expect(K9, 0, 0, 4'd0);
        scan_expect(K9, 0, 0, 4'd0);
        scan_expect(K9, 1, 1, 4'd9);
        scan_expect(K9, 0, 1, 4'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
